// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory arbiter and its lane formatter.
package mem_pkg;

    localparam int unsigned B_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_e;

    // Misaligned half/word or the reserved size encoding.
    function automatic logic access_err(size_e size, logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = addr_lo[0];
            SZ_WORD: access_err = |addr_lo;
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_data_arbiter_if.sv
// Requester, response and data-memory signals of the arbiter, bundled as one bus.
interface mem_data_arbiter_if #(
    parameter int unsigned B_WIDTH = mem_pkg::B_WIDTH_DEF,
    parameter int unsigned N_REQ   = 2
);
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0]              req_we;
    logic [N_REQ-1:0][B_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0][1:0]         req_size;
    logic [N_REQ-1:0]              req_unsigned;
    logic [N_REQ-1:0][B_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]              rsp_valid;
    logic [B_WIDTH-1:0]            rsp_rdata;
    logic                          rsp_err;
    logic [B_WIDTH-1:0]            mem_addr;
    logic                          mem_read_en;
    logic                          mem_write_en;
    logic [B_WIDTH/8-1:0]          write_byte_en;
    logic [B_WIDTH-1:0]            mem_wdata;
    logic [B_WIDTH-1:0]            mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_read_en, mem_write_en, write_byte_en, mem_wdata
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane formatting: byte enables, write replication, read extraction/extension.
module mem_align
    import mem_pkg::*;
#(
    parameter int unsigned B_WIDTH = B_WIDTH_DEF
) (
    input  size_e                size_i,
    input  logic [1:0]           addr_lo_i,
    input  logic                 unsigned_i,
    input  logic [B_WIDTH-1:0]   wdata_i,
    input  logic [B_WIDTH-1:0]   rdata_i,
    output logic [B_WIDTH/8-1:0] be_o,
    output logic [B_WIDTH-1:0]   wdata_o,
    output logic [B_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NB = B_WIDTH / 8;

    logic [B_WIDTH-1:0] shifted;
    logic               sbit;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        sbit    = 1'b0;
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                be_o = NB'(1) << addr_lo_i;
                for (int unsigned k = 0; k < NB; k++) wdata_o[8*k +: 8] = wdata_i[7:0];
                sbit    = ~unsigned_i & shifted[7];
                rdata_o = {{(B_WIDTH-8){sbit}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o = NB'(3) << addr_lo_i;
                for (int unsigned k = 0; k < NB/2; k++) wdata_o[16*k +: 16] = wdata_i[15:0];
                sbit    = ~unsigned_i & shifted[15];
                rdata_o = {{(B_WIDTH-16){sbit}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be_o    = '1;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Round-robin arbiter granting N_REQ requesters single-beat access to a data memory.
module mem_data_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned B_WIDTH = B_WIDTH_DEF,
    parameter int unsigned N_REQ   = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_data_arbiter_if.slave bus
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        port_q;
    logic                 we_q, uns_q, err_q;
    size_e                size_q;
    logic [B_WIDTH-1:0]   addr_q, wdata_q;

    logic [PW-1:0]        gnt_idx, idx;
    logic                 gnt_any, accept;
    logic [B_WIDTH/8-1:0] al_be;
    logic [B_WIDTH-1:0]   al_wdata, al_rdata;

    // ptr_q holds the first port to search, i.e. one past the last grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
            idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
        end
    end

    assign accept = (state_q == ST_IDLE) && gnt_any;
    assign ptr_d  = !accept ? ptr_q
                  : (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            port_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                port_q  <= gnt_idx;
                we_q    <= bus.req_we[gnt_idx];
                uns_q   <= bus.req_unsigned[gnt_idx];
                size_q  <= size_e'(bus.req_size[gnt_idx]);
                addr_q  <= bus.req_addr[gnt_idx];
                wdata_q <= bus.req_wdata[gnt_idx];
                err_q   <= access_err(size_e'(bus.req_size[gnt_idx]), bus.req_addr[gnt_idx][1:0]);
            end
        end
    end

    mem_align #(.B_WIDTH(B_WIDTH)) u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (bus.mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

    // Every output decodes from state_q, so the async reset clears strobes immediately.
    always_comb begin
        bus.req_ready     = '0;
        bus.rsp_valid     = '0;
        bus.rsp_rdata     = '0;
        bus.rsp_err       = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_read_en   = 1'b0;
        bus.mem_write_en  = 1'b0;
        bus.write_byte_en = '0;
        bus.mem_wdata     = '0;
        case (state_q)
            ST_IDLE: if (rst && gnt_any) bus.req_ready[gnt_idx] = 1'b1;
            ST_ISSUE: begin
                if (!err_q) begin
                    bus.mem_addr     = {2'b00, addr_q[B_WIDTH-1:2]};
                    bus.mem_read_en  = ~we_q;
                    bus.mem_write_en = we_q;
                    if (we_q) begin
                        bus.write_byte_en = al_be;
                        bus.mem_wdata     = al_wdata;
                    end
                end
            end
            ST_RESP: begin
                bus.rsp_valid[port_q] = 1'b1;
                bus.rsp_err           = err_q;
                if (!err_q && !we_q) bus.rsp_rdata = al_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed bench for mem_data_arbiter with a registered-read byte-lane memory model.
module tb_mem_data_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mem_arr [16] = '{default: '0};

    localparam logic [31:0] RD_ADDR [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h12};
    localparam logic [1:0]  RD_SIZE [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    localparam logic        RD_UNS  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] RD_EXP  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                            32'hFFFFFFFF, 32'h000080FF};

    localparam logic        ER_WE   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] ER_ADDR [4] = '{32'h02, 32'h03, 32'h00, 32'h01};
    localparam logic [1:0]  ER_SIZE [4] = '{2'b10, 2'b01, 2'b11, 2'b10};

    mem_data_arbiter_if #(.B_WIDTH(32), .N_REQ(2)) bus ();

    mem_data_arbiter #(.B_WIDTH(32), .N_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_rdata <= mem_arr[bus.mem_addr[3:0]];
        if (bus.mem_write_en)
            for (int k = 0; k < 4; k++)
                if (bus.write_byte_en[k])
                    mem_arr[bus.mem_addr[3:0]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
    end

    // Raises valid on port p, waits for its grant, returns #1 after the accepting edge.
    task automatic start_req(input bit p, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wd,
                             output bit ok);
        bus.req_we[p]       = we;
        bus.req_addr[p]     = addr;
        bus.req_size[p]     = size;
        bus.req_unsigned[p] = uns;
        bus.req_wdata[p]    = wd;
        bus.req_valid[p]    = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            ok = bus.req_ready[p];
        end
        if (ok) @(posedge clk);
        #1 bus.req_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b exp 00", bus.req_ready); end
        checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {bus.mem_read_en, bus.mem_write_en}); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 00", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b exp 0", bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", bus.rsp_rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", bus.mem_addr); end
        checks++; if (bus.write_byte_en !== 4'h0) begin errors++; $display("FAIL rst_be: got %b exp 0000", bus.write_byte_en); end
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int         n = 0;
        int         last_c = 0;
        logic [1:0] last_g = 2'b00;
        logic [1:0] exp_g;
        bus.req_we       = 2'b00;
        bus.req_unsigned = 2'b00;
        bus.req_size[0]  = SZ_WORD;
        bus.req_size[1]  = SZ_WORD;
        bus.req_addr[0]  = 32'h10;
        bus.req_addr[1]  = 32'h04;
        bus.req_valid    = 2'b11;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) begin
                checks++; if (bus.rsp_valid !== last_g) begin errors++; $display("FAIL rr_rsp_owner: got %b exp %b", bus.rsp_valid, last_g); end
            end
            if (bus.req_ready != 2'b00) begin
                exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (bus.req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", n, bus.req_ready, exp_g); end
                if (n > 0) begin
                    checks++; if (c - last_c != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d exp 3", n, c - last_c); end
                end
                last_g = bus.req_ready;
                last_c = c;
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_timeout: got %0d grants exp 4", n); end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_word_write_read();
        bit ok;
        start_req(1'b0, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEADBEEF, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ww_accept: got ready=0 exp ready=1"); end
        checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b01) begin errors++; $display("FAIL ww_strobes: got %b exp 01", {bus.mem_read_en, bus.mem_write_en}); end
        checks++; if (bus.mem_addr !== 32'h4) begin errors++; $display("FAIL ww_mem_addr: got %h exp 4", bus.mem_addr); end
        checks++; if (bus.write_byte_en !== 4'b1111) begin errors++; $display("FAIL ww_be: got %b exp 1111", bus.write_byte_en); end
        checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ww_wdata: got %h exp deadbeef", bus.mem_wdata); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL ww_rsp_valid: got %b exp 01", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL ww_rsp_rdata: got %h exp 0", bus.rsp_rdata); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL ww_rsp_pulse: got %b exp 00", bus.rsp_valid); end
        start_req(1'b0, 1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got ready=0 exp ready=1"); end
        checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b10) begin errors++; $display("FAIL wr_strobes: got %b exp 10", {bus.mem_read_en, bus.mem_write_en}); end
        checks++; if (bus.mem_addr !== 32'h4) begin errors++; $display("FAIL wr_mem_addr: got %h exp 4", bus.mem_addr); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL wr_rsp_valid: got %b exp 01", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rsp_rdata: got %h exp deadbeef", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %b exp 0", bus.rsp_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_extend();
        bit ok;
        start_req(1'b1, 1'b1, 32'h10, SZ_WORD, 1'b0, 32'h80FF0000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ext_wr_accept: got ready=0 exp ready=1"); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL ext_wr_rsp_valid: got %b exp 10", bus.rsp_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            start_req(1'b0, 1'b0, RD_ADDR[i], RD_SIZE[i], RD_UNS[i], 32'h0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ext_accept%0d: got ready=0 exp ready=1", i); end
            checks++; if (bus.mem_addr !== 32'h4) begin errors++; $display("FAIL ext_mem_addr%0d: got %h exp 4", i, bus.mem_addr); end
            @(posedge clk); #1;
            checks++; if (bus.rsp_rdata !== RD_EXP[i]) begin errors++; $display("FAIL ext_rdata%0d: got %h exp %h", i, bus.rsp_rdata, RD_EXP[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_half_write();
        bit ok;
        start_req(1'b0, 1'b1, 32'h06, SZ_HALF, 1'b0, 32'h00001234, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hw_accept: got ready=0 exp ready=1"); end
        checks++; if (bus.mem_addr !== 32'h1) begin errors++; $display("FAIL hw_mem_addr: got %h exp 1", bus.mem_addr); end
        checks++; if (bus.write_byte_en !== 4'b1100) begin errors++; $display("FAIL hw_be: got %b exp 1100", bus.write_byte_en); end
        checks++; if (bus.mem_wdata !== 32'h12341234) begin errors++; $display("FAIL hw_wdata: got %h exp 12341234", bus.mem_wdata); end
        repeat (2) @(posedge clk); #1;
        start_req(1'b0, 1'b1, 32'h05, SZ_BYTE, 1'b0, 32'h000000AB, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bw_accept: got ready=0 exp ready=1"); end
        checks++; if (bus.write_byte_en !== 4'b0010) begin errors++; $display("FAIL bw_be: got %b exp 0010", bus.write_byte_en); end
        checks++; if (bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL bw_wdata: got %h exp abababab", bus.mem_wdata); end
        repeat (2) @(posedge clk); #1;
        start_req(1'b0, 1'b0, 32'h04, SZ_WORD, 1'b0, 32'h0, ok);
        @(posedge clk); #1;
        checks++; if (bus.rsp_rdata !== 32'h1234AB00) begin errors++; $display("FAIL hw_readback: got %h exp 1234ab00", bus.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        bit ok;
        for (int i = 0; i < 4; i++) begin
            start_req(1'b0, ER_WE[i], ER_ADDR[i], ER_SIZE[i], 1'b0, 32'hFFFFFFFF, ok);
            checks++; if (!ok) begin errors++; $display("FAIL err_accept%0d: got ready=0 exp ready=1", i); end
            checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin errors++; $display("FAIL err_strobes%0d: got %b exp 00", i, {bus.mem_read_en, bus.mem_write_en}); end
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL err_rsp_valid%0d: got %b exp 01", i, bus.rsp_valid); end
            checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL err_flag%0d: got %b exp 1", i, bus.rsp_err); end
            checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata%0d: got %h exp 0", i, bus.rsp_rdata); end
            @(posedge clk); #1;
            checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL err_clear%0d: got %b exp 0", i, bus.rsp_err); end
        end
        start_req(1'b0, 1'b0, 32'h00, SZ_WORD, 1'b0, 32'h0, ok);
        @(posedge clk); #1;
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_no_write: got %h exp 0", bus.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midissue();
        bit ok;
        int seen = 0;
        start_req(1'b0, 1'b1, 32'h20, SZ_WORD, 1'b0, 32'h00000055, ok);
        checks++; if (bus.mem_write_en !== 1'b1) begin errors++; $display("FAIL mid_issue_wr: got %b exp 1", bus.mem_write_en); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00) begin errors++; $display("FAIL mid_strobes: got %b exp 00", {bus.mem_read_en, bus.mem_write_en}); end
        checks++; if (bus.write_byte_en !== 4'h0) begin errors++; $display("FAIL mid_be: got %b exp 0000", bus.write_byte_en); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_mem_addr: got %h exp 0", bus.mem_addr); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen++;
            if (c == 1) rst = 1'b1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses exp 0", seen); end
        @(posedge clk); #1;
        bus.req_we       = 2'b00;
        bus.req_size[0]  = SZ_WORD;
        bus.req_size[1]  = SZ_WORD;
        bus.req_addr[0]  = 32'h20;
        bus.req_addr[1]  = 32'h04;
        bus.req_valid    = 2'b11;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b exp 01", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        checks++; if (bus.mem_read_en !== 1'b1) begin errors++; $display("FAIL mid_rd_strobe: got %b exp 1", bus.mem_read_en); end
        checks++; if (bus.mem_addr !== 32'h8) begin errors++; $display("FAIL mid_rd_addr: got %h exp 8", bus.mem_addr); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL mid_rd_valid: got %b exp 01", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL mid_discarded_write: got %h exp 0", bus.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst              = 1'b0;
        bus.req_valid    = '0;
        bus.req_we       = '0;
        bus.req_addr     = '0;
        bus.req_size     = '0;
        bus.req_unsigned = '0;
        bus.req_wdata    = '0;
        test_reset();
        test_round_robin();
        test_word_write_read();
        test_read_extend();
        test_half_write();
        test_error();
        test_reset_midissue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_data_arbiter.md
MEM_DATA_ARBITER -- requirements
Module: mem_data_arbiter

Interface
REQ-001 SHALL have parameter B_WIDTH, default 32, data word width in bits (multiple of 8; the alignment rules below assume 32).
REQ-002 SHALL have parameter N_REQ, default 2, number of requester ports (indexed 0..N_REQ-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-port request valid.
REQ-006 SHALL have port req_ready  output  N_REQ  per-port request accepted this cycle.
REQ-007 SHALL have port req_we  input  N_REQ  per-port write (1) or read (0).
REQ-008 SHALL have port req_addr  input  N_REQ x B_WIDTH  per-port byte address.
REQ-009 SHALL have port req_size  input  N_REQ x 2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned  input  N_REQ  zero-extend (1) or sign-extend (0) read data.
REQ-011 SHALL have port req_wdata  input  N_REQ x B_WIDTH  write data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  N_REQ  one-cycle response pulse to the owning port.
REQ-013 SHALL have port rsp_rdata  output  B_WIDTH  formatted read data, shared by all ports.
REQ-014 SHALL have port rsp_err  output  1  misaligned or illegal-size access.
REQ-015 SHALL have port mem_addr  output  B_WIDTH  word index to the data memory.
REQ-016 SHALL have ports mem_read_en and mem_write_en  output  1 each  memory strobes, never high together.
REQ-017 SHALL have port write_byte_en  output  B_WIDTH/8  per-lane write enable.
REQ-018 SHALL have ports mem_wdata  output  B_WIDTH and mem_rdata  input  B_WIDTH  memory write data and registered read data, valid one cycle after mem_read_en.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, RESP: IDLE->ISSUE on accept, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-020 SHALL assert req_ready only in IDLE, to at most one port: the granted port, and only while its req_valid is high.
REQ-021 SHALL arbitrate round-robin: search starts at the port after the last granted one; after reset the search starts at port 0.
REQ-022 SHALL register the granted request (port, we, addr, size, unsigned, wdata) at accept.
REQ-023 SHALL, in ISSUE, drive mem_addr = addr[B_WIDTH-1:2] zero-extended, and mem_read_en = ~we or mem_write_en = we, for exactly one cycle.
REQ-024 SHALL set byte enables to 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word.
REQ-025 SHALL replicate write data across lanes: byte x4, half x2.
REQ-026 SHALL, in RESP, pulse rsp_valid[port]; for reads rsp_rdata = (mem_rdata >> 8*addr[1:0]) truncated to size, then sign- or zero-extended.
REQ-027 SHALL give rsp_rdata = 0 for writes; request accept edge to rsp_valid is 2 cycles for every access.
REQ-028 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, and size 11 as errors: no memory strobe in ISSUE, then rsp_err=1 and rsp_rdata=0 with normal timing.
REQ-029 SHALL hold mem strobes, write_byte_en, rsp_valid and rsp_err at 0 outside ISSUE/RESP respectively.
REQ-030 SHALL serve back-to-back requests at one per 3 cycles; a port kept valid is re-granted only after other valid ports have been served.

Reset
REQ-031 SHALL, while rst=0, force IDLE, clear the round-robin pointer, and drive every output to 0, including mid-ISSUE strobes asynchronously.
REQ-032 SHALL discard any in-flight access on reset and never emit its response.

Structure
REQ-033 SHALL take the size encoding, the FSM state enum and the B_WIDTH default from shared package mem_pkg.
REQ-034 SHALL place lane formatting (byte enables, write replication, read extraction and extension) in the combinational sub-module mem_align.

Verification
REQ-035 SHALL test: port0 word write addr 0x10 data 0xDEADBEEF -> mem_addr 0x4, write_byte_en 1111; read back returns 0xDEADBEEF 2 cycles after accept.
REQ-036 SHALL test: byte read addr 0x13 signed, word 0x80FF0000 -> rsp_rdata 0xFFFFFF80; the same read unsigned -> 0x00000080.
REQ-037 SHALL test: half write addr 0x06 data 0x1234 -> write_byte_en 1100, mem_wdata 0x12341234.
REQ-038 SHALL test: both ports valid continuously -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-039 SHALL test: word read addr 0x02 -> no mem_read_en, rsp_err=1 and rsp_rdata=0 2 cycles after accept.
REQ-040 SHALL test: rst low during ISSUE -> strobes drop immediately, no rsp_valid follows, and the first grant after reset goes to port 0.
